// File: rtl/decoder_4x16_if.sv
// Select bus between a requester and the 4-to-16 decoder: index and enable in,
// decoded select word and its valid flag out.
interface decoder_4x16_if;
  logic        en;
  logic [3:0]  in;
  logic [15:0] out;
  logic        valid;

  modport master (output en, output in, input out, input valid);
  modport slave  (input en, input in, output out, output valid);
endinterface

// File: rtl/decoder_4x16.sv
// 4-to-16 one-hot (or one-cold) select decoder with optional output register,
// used for register-file write-select and peripheral chip-select.
module decoder_4x16 #(
  parameter bit ACTIVE_HIGH = 1'b1,
  parameter bit REGISTERED  = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_4x16_if.slave  bus
);

  localparam logic [15:0] INACTIVE = ACTIVE_HIGH ? 16'h0000 : 16'hFFFF;

  // A shift by an X/Z index yields X, so unknown selects propagate to the output.
  function automatic logic [15:0] decode_onehot(input logic [3:0] idx);
    logic [15:0] word;
    word = 16'h0001 << idx;
    return word;
  endfunction

  logic [15:0] dec_s;
  logic        valid_s;

  // Next select word: decoded index when enabled, all-inactive otherwise.
  always_comb begin
    dec_s   = INACTIVE;
    valid_s = 1'b0;
    if (bus.en) begin
      dec_s   = ACTIVE_HIGH ? decode_onehot(bus.in) : ~decode_onehot(bus.in);
      valid_s = 1'b1;
    end else begin
      dec_s   = INACTIVE;
      valid_s = 1'b0;
    end
  end

  generate
    if (REGISTERED) begin : g_reg
      logic [15:0] out_r;
      logic        valid_r;

      // Output register: reset drops the selects at once, without a clock.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_r   <= INACTIVE;
          valid_r <= 1'b0;
        end else begin
          out_r   <= dec_s;
          valid_r <= valid_s;
        end
      end

      assign bus.out   = out_r;
      assign bus.valid = valid_r;
    end else begin : g_comb
      logic unused_s;
      assign unused_s  = clk ^ rst_n;
      assign bus.out   = dec_s;
      assign bus.valid = valid_s;
    end
  endgenerate

endmodule

// File: tb/tb_decoder_4x16.sv
// Bench for decoder_4x16: table-driven sweep and enable gating, plus reset,
// one-cold and combinational-mode sequences.
module tb_decoder_4x16;

  typedef struct {
    logic        en;
    logic [3:0]  in;
    logic [15:0] exp_out;
    logic        exp_valid;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  decoder_4x16_if bus_hi ();
  decoder_4x16_if bus_lo ();
  decoder_4x16_if bus_c ();

  decoder_4x16 #(.ACTIVE_HIGH(1'b1), .REGISTERED(1'b1)) u_hi (.clk(clk), .rst_n(rst_n), .bus(bus_hi));
  decoder_4x16 #(.ACTIVE_HIGH(1'b0), .REGISTERED(1'b1)) u_lo (.clk(clk), .rst_n(rst_n), .bus(bus_lo));
  decoder_4x16 #(.ACTIVE_HIGH(1'b1), .REGISTERED(1'b0)) u_c  (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act_out, input logic [15:0] exp_out,
                       input logic act_valid, input logic exp_valid);
    tests++;
    if (act_out !== exp_out || act_valid !== exp_valid) begin
      fails++;
      $display("FAIL %s: out=%h valid=%b, required out=%h valid=%b",
               name, act_out, act_valid, exp_out, exp_valid);
    end
  endtask

  // One-hot invariant on the active-high registered instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus_hi.valid === 1'b1) begin
      tests++;
      if ($countones(bus_hi.out) != 1) begin
        fails++;
        $display("FAIL onehot_invariant: out=%h, required exactly one bit set", bus_hi.out);
      end
    end
  end

  initial begin
    vec_t vecs[19];
    vecs[0]  = '{1'b1, 4'd0,  16'h0001, 1'b1};
    vecs[1]  = '{1'b1, 4'd1,  16'h0002, 1'b1};
    vecs[2]  = '{1'b1, 4'd2,  16'h0004, 1'b1};
    vecs[3]  = '{1'b1, 4'd3,  16'h0008, 1'b1};
    vecs[4]  = '{1'b1, 4'd4,  16'h0010, 1'b1};
    vecs[5]  = '{1'b1, 4'd5,  16'h0020, 1'b1};
    vecs[6]  = '{1'b1, 4'd6,  16'h0040, 1'b1};
    vecs[7]  = '{1'b1, 4'd7,  16'h0080, 1'b1};
    vecs[8]  = '{1'b1, 4'd8,  16'h0100, 1'b1};
    vecs[9]  = '{1'b1, 4'd9,  16'h0200, 1'b1};
    vecs[10] = '{1'b1, 4'd10, 16'h0400, 1'b1};
    vecs[11] = '{1'b1, 4'd11, 16'h0800, 1'b1};
    vecs[12] = '{1'b1, 4'd12, 16'h1000, 1'b1};
    vecs[13] = '{1'b1, 4'd13, 16'h2000, 1'b1};
    vecs[14] = '{1'b1, 4'd14, 16'h4000, 1'b1};
    vecs[15] = '{1'b1, 4'd15, 16'h8000, 1'b1};
    vecs[16] = '{1'b1, 4'd9,  16'h0200, 1'b1};
    vecs[17] = '{1'b0, 4'd9,  16'h0000, 1'b0};
    vecs[18] = '{1'b1, 4'd9,  16'h0200, 1'b1};

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus_hi.en = 1'b0; bus_hi.in = 4'd0;
    bus_lo.en = 1'b0; bus_lo.in = 4'd0;
    bus_c.en  = 1'b0; bus_c.in  = 4'd0;

    #12;
    check("reset_hi", bus_hi.out, 16'h0000, bus_hi.valid, 1'b0);
    check("reset_lo", bus_lo.out, 16'hFFFF, bus_lo.valid, 1'b0);

    // Combinational instance ignores reset and the clock entirely.
    bus_c.en = 1'b1; bus_c.in = 4'd2;
    #1 check("comb_in2", bus_c.out, 16'h0004, bus_c.valid, 1'b1);
    bus_c.in = 4'd14;
    #1 check("comb_in14", bus_c.out, 16'h4000, bus_c.valid, 1'b1);
    bus_c.en = 1'b0;
    #1 check("comb_disabled", bus_c.out, 16'h0000, bus_c.valid, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      bus_hi.en = vecs[i].en;
      bus_hi.in = vecs[i].in;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), bus_hi.out, vecs[i].exp_out, bus_hi.valid, vecs[i].exp_valid);
    end

    @(negedge clk);
    bus_lo.en = 1'b1; bus_lo.in = 4'd3;
    @(posedge clk);
    #1 check("lo_in3", bus_lo.out, 16'hFFF7, bus_lo.valid, 1'b1);
    @(negedge clk);
    bus_lo.en = 1'b0;
    @(posedge clk);
    #1 check("lo_disabled", bus_lo.out, 16'hFFFF, bus_lo.valid, 1'b0);

    @(negedge clk);
    bus_hi.en = 1'b1; bus_hi.in = 4'd5;
    bus_lo.en = 1'b1; bus_lo.in = 4'd5;
    @(posedge clk);
    #1 check("pre_reset_in5", bus_hi.out, 16'h0020, bus_hi.valid, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("async_reset_hi", bus_hi.out, 16'h0000, bus_hi.valid, 1'b0);
    check("async_reset_lo", bus_lo.out, 16'hFFFF, bus_lo.valid, 1'b0);
    @(posedge clk);
    #1 check("reset_held", bus_hi.out, 16'h0000, bus_hi.valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("release_waits_edge", bus_hi.out, 16'h0000, bus_hi.valid, 1'b0);
    @(posedge clk);
    #1 check("post_release", bus_hi.out, 16'h0020, bus_hi.valid, 1'b1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
